// File: rtl/single_pkg.sv
// Shared types and constants for the single-precision reduction stage.
package single_pkg;

  typedef logic [31:0] float32_t;

  localparam float32_t FP_ZERO = 32'h0000_0000;
  localparam float32_t FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sum_state_t;

endpackage

// File: rtl/single_sum_v_add.sv
// One-clock IEEE-754 single-precision adder, round-to-nearest-even.
// The result register is loaded every cycle; only out_valid carries meaning.
module single_add_1clk
  import single_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  input  float32_t a,
  input  float32_t b,
  output logic     out_valid,
  output float32_t c
);

  logic     vld_p1;
  float32_t res_p1;

  // Leading-zero count of a 27-bit mantissa, 27 when all zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  // m holds {hidden, frac[22:0], guard, round, sticky}; a clear hidden bit
  // means a denormal, whose exponent field becomes 0 unless rounding carries in.
  function automatic float32_t round_pack(input logic sgn, input logic [9:0] e,
                                          input logic [26:0] m);
    logic       inc;
    logic [24:0] mr;
    logic [9:0]  ef;
    inc = m[2] & (m[1] | m[0] | m[3]);
    mr  = {1'b0, m[26:3]} + 25'(inc);
    if (mr[24]) begin
      ef = e + 10'd1;
      mr = mr >> 1;
    end else if (mr[23]) begin
      ef = e;
    end else begin
      ef = 10'd0;
    end
    if (ef >= 10'd255) return {sgn, 8'hFF, 23'd0};
    return {sgn, ef[7:0], mr[22:0]};
  endfunction

  // Full float add: specials first, then align, add/subtract, normalise, round.
  function automatic float32_t fp_add(input float32_t x, input float32_t y);
    logic        x_nan, y_nan, x_inf, y_inf, sub;
    float32_t    big, sml;
    logic [9:0]  eb, es, e;
    logic [7:0]  d;
    logic [27:0] mb, ms, m;
    logic [55:0] shw;
    logic [4:0]  lz, sh;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) return FP_QNAN;
    if (x_inf) return x;
    if (y_inf) return y;
    if (x[30:0] >= y[30:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    eb  = (big[30:23] == 8'd0) ? 10'd1 : {2'b00, big[30:23]};
    es  = (sml[30:23] == 8'd0) ? 10'd1 : {2'b00, sml[30:23]};
    mb  = {1'b0, (big[30:23] != 8'd0), big[22:0], 3'b000};
    ms  = {1'b0, (sml[30:23] != 8'd0), sml[22:0], 3'b000};
    d   = ((eb - es) > 10'd28) ? 8'd28 : 8'(eb - es);
    shw = {ms, 28'd0} >> d;
    ms  = {shw[55:29], shw[28] | (|shw[27:0])};
    sub = big[31] ^ sml[31];
    m   = sub ? (mb - ms) : (mb + ms);
    e   = eb;
    if (m == 28'd0) return {big[31] & ~sub, 31'd0};
    if (m[27]) begin
      m = {1'b0, m[27:2], m[1] | m[0]};
      e = e + 10'd1;
    end else begin
      lz = lzc27(m[26:0]);
      sh = (10'(lz) < (e - 10'd1)) ? lz : 5'(e - 10'd1);
      m  = m << sh;
      e  = e - 10'(sh);
    end
    return round_pack(big[31], e, m[26:0]);
  endfunction

  // Stage p0 -> p1: register the sum and its valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= in_valid;
    res_p1 <= fp_add(a, b);
  end

  assign out_valid = vld_p1;
  assign c         = res_p1;

endmodule

// File: rtl/single_sum_v.sv
// Sequential float reduction: ((v0+v1)+v2)+... through one shared adder.
module single_sum_v
  import single_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  float32_t vector_in [WIDTH],
  output logic     busy,
  output logic     done,
  output float32_t sum
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  sum_state_t    state, state_nxt;
  float32_t      vec_q [WIDTH];
  float32_t      acc;
  logic [IW-1:0] idx;
  logic          add_in_valid, add_out_valid;
  float32_t      add_a, add_b, add_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (WIDTH == 1) ? DONE : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (add_out_valid) state_nxt = (idx == LAST) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; the adder is kept quiet while reset is held.
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    add_in_valid = (state == ISSUE) && !rst;
  end

  // Operand capture; only the start cycle's vector is ever used.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && start) vec_q <= vector_in;
  end

  // Accumulator, element index and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= FP_ZERO;
      idx <= '0;
      sum <= FP_ZERO;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= vector_in[0];
          idx <= IW'(1);
          if (WIDTH == 1) sum <= vector_in[0];
        end
        WAIT: if (add_out_valid) begin
          acc <= add_c;
          idx <= idx + IW'(1);
          if (idx == LAST) sum <= add_c;
        end
        default: ;
      endcase
    end
  end

  // Operand select for the shared adder.
  always_comb begin
    add_a = rst ? FP_ZERO : acc;
    add_b = FP_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      if (!rst && idx == IW'(i)) add_b = vec_q[i];
    end
  end

  single_add_1clk u_add (
    .clk       (clk),
    .rst_n     (~rst),
    .in_valid  (add_in_valid),
    .a         (add_a),
    .b         (add_b),
    .out_valid (add_out_valid),
    .c         (add_c)
  );

endmodule

// File: tb/tb_single_sum_v.sv
// Directed bench for single_sum_v at WIDTH 4, 1 and 3.
module tb_single_sum_v;
  import single_pkg::*;

  logic     clk, rst;
  logic     start4, start1, start3;
  float32_t vec4 [4];
  float32_t vec1 [1];
  float32_t vec3 [3];
  logic     busy4, done4, busy1, done1, busy3, done3;
  float32_t sum4, sum1, sum3;

  int total, bad;
  int cyc, n4, n1, at1, n3, at3, b4, iv1;
  int       a4 [2];
  float32_t s4 [2];
  float32_t ones [10];

  single_sum_v #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(start4), .vector_in(vec4),
                               .busy(busy4), .done(done4), .sum(sum4));
  single_sum_v #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(start1), .vector_in(vec1),
                               .busy(busy1), .done(done1), .sum(sum1));
  single_sum_v #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .start(start3), .vector_in(vec3),
                               .busy(busy3), .done(done3), .sum(sum3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; n4 = 0; n1 = 0; at1 = 0; n3 = 0; at3 = 0; b4 = 0; iv1 = 0;
    a4[0] = 0; a4[1] = 0; s4[0] = '0; s4[1] = '0;
  endtask

  // One rising edge; cycle k is the interval following edge k-1.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done4) begin
      if (n4 < 2) begin
        a4[n4] = cyc;
        s4[n4] = sum4;
      end
      n4++;
    end
    if (done1) begin n1++; at1 = cyc; end
    if (done3) begin n3++; at3 = cyc; end
    if (busy4) b4++;
    if (u1.add_in_valid) iv1++;
  endtask

  task automatic set_row(input int k);
    vec4[0] = ones[k];
    vec4[1] = 32'h4000_0000;
    vec4[2] = 32'h4040_0000;
    vec4[3] = 32'h4080_0000;
  endtask

  initial begin
    ones = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
             32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000};
    clk = 0; rst = 1; start4 = 0; start1 = 0; start3 = 0;
    total = 0; bad = 0;
    vec4 = '{default: '0}; vec1 = '{default: '0}; vec3 = '{default: '0};
    clr();
    tick(); tick();
    rst = 0;
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_done4", done4, 1'b0);
    chk("rst_sum4",  sum4, 32'h0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_sum1",  sum1, 32'h0);
    chk("rst_sum3",  sum3, 32'h0);
    tick();

    // 1+2+3+4 = 10.0
    set_row(0); start4 = 1; clr();
    tick(); start4 = 0;
    chk("s1_busy_c1", busy4, 1'b1);
    repeat (9) tick();
    chk("s1_done_n",   n4, 1);
    chk("s1_done_cyc", a4[0], 7);
    chk("s1_sum",      s4[0], 32'h4120_0000);
    chk("s1_busy_n",   b4, 7);
    chk("s1_sum_hold", sum4, 32'h4120_0000);

    // WIDTH=1 passes the single element straight through
    vec1[0] = 32'hC049_0FDB; start1 = 1; clr();
    tick(); start1 = 0;
    chk("s2_done_c1", done1, 1'b1);
    repeat (3) tick();
    chk("s2_done_n",   n1, 1);
    chk("s2_done_cyc", at1, 1);
    chk("s2_sum",      sum1, 32'hC049_0FDB);
    chk("s2_no_issue", iv1, 0);

    // +Inf + 1 + -Inf + 1 -> NaN
    vec4 = '{32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000};
    start4 = 1; clr();
    tick(); start4 = 0;
    repeat (9) tick();
    chk("s3_done_n",   n4, 1);
    chk("s3_done_cyc", a4[0], 7);
    chk("s3_is_nan",   {31'd0, (s4[0][30:23] == 8'hFF) && (s4[0][22:0] != 23'd0)}, 32'd1);
    chk("s3_qnan",     s4[0], 32'h7FC0_0000);

    // start held 10 cycles while the vector changes every cycle
    clr(); set_row(0); start4 = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k < 9) set_row(k + 1);
    end
    start4 = 0;
    repeat (8) tick();
    chk("s4_done_n",    n4, 2);
    chk("s4_done0_cyc", a4[0], 7);
    chk("s4_sum0",      s4[0], 32'h4120_0000);
    chk("s4_done1_cyc", a4[1], 15);
    chk("s4_sum1",      s4[1], 32'h4190_0000);

    // reset sampled at edge 4 aborts the run; restart at edge 6
    clr(); set_row(0); start4 = 1;
    tick(); start4 = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("s5_busy_c5", busy4, 1'b0);
    chk("s5_sum_c5",  sum4, 32'h0);
    chk("s5_done_c5", done4, 1'b0);
    tick();
    vec4 = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    start4 = 1;
    tick(); start4 = 0;
    repeat (8) tick();
    chk("s5_done_n",   n4, 1);
    chk("s5_done_cyc", a4[0], 13);
    chk("s5_sum",      s4[0], 32'h4100_0000);

    // WIDTH=3: 1+2+3 = 6.0
    vec3 = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    start3 = 1; clr();
    tick(); start3 = 0;
    repeat (6) tick();
    chk("s6a_done_n",   n3, 1);
    chk("s6a_done_cyc", at3, 5);
    chk("s6a_sum",      sum3, 32'h40C0_0000);

    // (2^24 + 1) rounds to 2^24, minus 2^24 gives +0
    vec3 = '{32'h4B80_0000, 32'h3F80_0000, 32'hCB80_0000};
    start3 = 1; clr();
    tick(); start3 = 0;
    repeat (6) tick();
    chk("s6b_done_n",   n3, 1);
    chk("s6b_done_cyc", at3, 5);
    chk("s6b_sum",      sum3, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
